ws2812_rx_decoder: RTL and testbench

- Single-wire WS2812B line decoder; the receive-side counterpart of the team's NRZ pulse encoder.
- Samples the serial DIN waveform on sys_clk (50 MHz).
- Classifies each high pulse as a 0 or 1 code and assembles 24-bit GRB words MSB-first.
- Counts pixels per frame, detects the latch/reset low period, and flags malformed pulses.
- Used as a loopback monitor on the LED data line and as a bench/checker for the 8x8 matrix driver.

---
 rtl/ws2812_pkg.sv | 35 +++
 rtl/ws2812_pulse_meas.sv | 99 +++++++++
 rtl/ws2812_rx_decoder.sv | 158 +++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and FSM encoding for the WS2812B receive path.
// Optional feature macro used by the top: WS2812_RX_FWD_EN (cascade forwarding on dout).
package ws2812_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int T0H        = 15;
    localparam int T1H        = 47;
    localparam int T_BIT      = 62;
    localparam int T_RESET    = 2500;

    localparam int BIT_THRESH = 31;
    localparam int MIN_HIGH   = 5;
    localparam int MAX_HIGH   = 100;
    localparam int MAX_PIX    = 64;

    localparam int PIX_W      = $clog2(MAX_PIX);
    localparam int PCNT_W     = PIX_W + 1;
    localparam int HI_W       = $clog2(MAX_HIGH + 2);
    localparam int LO_W       = $clog2(T_RESET + 1);

    // GRB word layout, first received bit lands in bit 23
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        MEAS_HIGH = 2'd2
    } meas_state_e;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Synchronises DIN, detects edges and measures high-pulse widths and low periods.
// Emits a fall strobe with the pulse width, an over-long strobe and a frame-reset strobe.
module ws2812_pulse_meas
    import ws2812_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            din,
    output logic            fall_o,
    output logic [HI_W-1:0] width_o,
    output logic            long_o,
    output logic            reset_seen_o
`ifdef WS2812_RX_FWD_EN
    ,
    output logic            sync_o
`endif
);

    localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);
    localparam logic [HI_W-1:0] HI_SAT = HI_W'(MAX_HIGH + 1);
    localparam logic [LO_W-1:0] LO_ONE = LO_W'(1);
    localparam logic [LO_W-1:0] LO_END = LO_W'(T_RESET);

    logic            sync1_q, sync2_q, dly_q;
    meas_state_e     state_q, state_d;
    logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
    logic            rise, fall;

    assign rise = sync2_q & ~dly_q;
    assign fall = ~sync2_q & dly_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            state_q  <= IDLE;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        fall_o       = 1'b0;
        long_o       = 1'b0;
        reset_seen_o = 1'b0;
        width_o      = hi_cnt_q;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    lo_cnt_d = '0;
                end else begin
                    lo_cnt_d = lo_cnt_q + LO_ONE;
                    if (lo_cnt_q == LO_END - LO_ONE) state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // the rise cycle is already one high cycle of the pulse
                if (rise) begin
                    hi_cnt_d = HI_ONE;
                    state_d  = MEAS_HIGH;
                end else if (lo_cnt_q != LO_END) begin
                    lo_cnt_d     = lo_cnt_q + LO_ONE;
                    reset_seen_o = (lo_cnt_q == LO_END - LO_ONE);
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    fall_o   = 1'b1;
                    lo_cnt_d = LO_ONE;
                    state_d  = WAIT_HIGH;
                end else if (hi_cnt_q == HI_SAT) begin
                    long_o   = 1'b1;
                    lo_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    hi_cnt_d = hi_cnt_q + HI_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WS2812_RX_FWD_EN
    assign sync_o = sync2_q;
`endif

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812B line decoder: classifies pulses, assembles GRB words and tracks frames.
// Define WS2812_RX_FWD_EN to add the dout cascade-forwarding output.
module ws2812_rx_decoder
    import ws2812_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic        rgb_valid,
    output logic [5:0]  pix_idx,
    output logic        frame_done,
    output logic [6:0]  pix_count,
    output logic        err
`ifdef WS2812_RX_FWD_EN
    ,
    output logic        dout
`endif
);

    localparam logic [HI_W-1:0]   HI_MIN    = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0]   HI_THR    = HI_W'(BIT_THRESH);
    localparam logic [PCNT_W-1:0] PIX_FULL  = PCNT_W'(MAX_PIX);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(MAX_PIX - 1);

    logic            fall_s, long_s, reset_seen_s;
    logic [HI_W-1:0] width_s;
    logic            good_bit, glitch, word_done;

    logic [23:0]       shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [23:0]       rgb_data_q, rgb_data_d;
    logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [PCNT_W-1:0] pix_count_q, pix_count_d;
    logic              rgb_valid_q, rgb_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

`ifdef WS2812_RX_FWD_EN
    logic sync_s;
`endif

    ws2812_pulse_meas u_meas (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .din          (din),
        .fall_o       (fall_s),
        .width_o      (width_s),
        .long_o       (long_s),
        .reset_seen_o (reset_seen_s)
`ifdef WS2812_RX_FWD_EN
        ,
        .sync_o       (sync_s)
`endif
    );

    assign glitch    = fall_s && (width_s < HI_MIN);
    assign good_bit  = fall_s && !glitch;
    assign word_done = good_bit && (bit_cnt_q == 5'd23);

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        rgb_data_d   = rgb_data_q;
        pix_idx_d    = pix_idx_q;
        pix_count_d  = pix_count_q;
        rgb_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = glitch;
        if (good_bit) begin
            shift_d = {shift_q[22:0], (width_s >= HI_THR)};
            if (word_done) begin
                rgb_data_d  = shift_d;
                rgb_valid_d = 1'b1;
                bit_cnt_d   = '0;
                // a word beyond the frame capacity is still shown, at the last index
                if (pix_cnt_q == PIX_FULL) begin
                    pix_idx_d = PIX_LAST;
                    err_d     = 1'b1;
                end else begin
                    pix_idx_d = pix_cnt_q[PIX_W-1:0];
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
        if (long_s) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            pix_cnt_d = '0;
        end
        if (reset_seen_s && (bit_cnt_q != 5'd0 || pix_cnt_q != '0)) begin
            frame_done_d = 1'b1;
            pix_count_d  = pix_cnt_q;
            err_d        = (bit_cnt_q != 5'd0);
            bit_cnt_d    = '0;
            pix_cnt_d    = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            rgb_data_q   <= '0;
            pix_idx_q    <= '0;
            pix_count_q  <= '0;
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            rgb_data_q   <= rgb_data_d;
            pix_idx_q    <= pix_idx_d;
            pix_count_q  <= pix_count_d;
            rgb_valid_q  <= rgb_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign rgb_data   = rgb_data_q;
    assign rgb_valid  = rgb_valid_q;
    assign pix_idx    = pix_idx_q;
    assign frame_done = frame_done_q;
    assign pix_count  = pix_count_q;
    assign err        = err_q;

`ifdef WS2812_RX_FWD_EN
    // dout stays low through the first word of a frame, then mirrors the line
    logic fwd_q, fwd_d, dout_q;

    always_comb begin
        fwd_d = fwd_q;
        if (word_done) fwd_d = 1'b1;
        if (reset_seen_s || long_s) fwd_d = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            fwd_q  <= fwd_d;
            dout_q <= fwd_d & sync_s;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: pulse-level decoding model plus literal spot checks.
module tb_ws2812_rx_decoder;

    localparam int MIN_HIGH   = 5;
    localparam int MAX_HIGH   = 100;
    localparam int BIT_THRESH = 31;
    localparam int MAX_PIX    = 64;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        din       = 1'b0;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic [5:0]  pix_idx;
    logic        frame_done;
    logic [6:0]  pix_count;
    logic        err;

    ws2812_rx_decoder dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din),
        .rgb_data   (rgb_data),
        .rgb_valid  (rgb_valid),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .pix_count  (pix_count),
        .err        (err)
    );

    // clock / reset
    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // scoreboard state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [30:0] exp_word_q[$];   // {overflow_err, pix_idx, data}
    logic [7:0]  exp_frame_q[$];  // {partial_err, pix_count}
    int          exp_err  = 0;
    int          err_seen = 0;
    int          word_fall_cyc = 0;
    logic [23:0] last_rgb = '0;
    logic [6:0]  last_pc  = '0;
    logic [30:0] e_word;
    logic [7:0]  e_frame;

    // decoding model
    logic [23:0] m_word = '0;
    int          m_bits = 0;
    int          m_pix  = 0;
    bit          m_idle = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit model_pulse(input int h);
        if (m_idle) return 1'b0;
        if (h < MIN_HIGH) begin
            exp_err++;
            return 1'b0;
        end
        if (h > MAX_HIGH) begin
            exp_err++;
            m_idle = 1'b1;
            m_bits = 0;
            m_pix  = 0;
            return 1'b0;
        end
        m_word = {m_word[22:0], (h >= BIT_THRESH)};
        m_bits++;
        if (m_bits == 24) begin
            m_bits = 0;
            if (m_pix == MAX_PIX) begin
                exp_err++;
                exp_word_q.push_back({1'b1, 6'd63, m_word});
            end else begin
                exp_word_q.push_back({1'b0, 6'(m_pix), m_word});
                m_pix++;
            end
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_frame_end();
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_bits != 0 || m_pix != 0) begin
            exp_frame_q.push_back({(m_bits != 0), 7'(m_pix)});
            if (m_bits != 0) exp_err++;
            m_bits = 0;
            m_pix  = 0;
        end
    endfunction

    // driver tasks
    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        bit done;
        done = model_pulse(h);
        hold(1'b1, h);
        if (done) word_fall_cyc = cyc;
        hold(1'b0, l);
    endtask

    task automatic send_word(input logic [23:0] w, input bit fast);
        int h;
        for (int i = 23; i >= 0; i--) begin
            if (fast) begin
                h = w[i] ? 33 : 6;
                pulse(h, 2);
            end else begin
                h = w[i] ? 47 : 15;
                pulse(h, 62 - h);
            end
        end
    endtask

    task automatic frame_end(input int n);
        model_frame_end();
        hold(1'b0, n);
    endtask

    task automatic checkpoint(input string name);
        repeat (8) begin
            @(posedge sys_clk);
            #1;
        end
        chk({name, "_words_pending"}, exp_word_q.size(), 0);
        chk({name, "_frames_pending"}, exp_frame_q.size(), 0);
        chk({name, "_err_count"}, err_seen, exp_err);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_rgb_data"}, rgb_data, 0);
        chk({name, "_rgb_valid"}, rgb_valid, 0);
        chk({name, "_pix_idx"}, pix_idx, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_pix_count"}, pix_count, 0);
        chk({name, "_err"}, err, 0);
    endtask

    // compare process: every strobe is matched against the model's expectations
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (err) err_seen++;
            if (rgb_valid) begin
                if (exp_word_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rgb_valid: got data %0h, expected no word", rgb_data);
                end else begin
                    e_word = exp_word_q.pop_front();
                    chk("rgb_data", rgb_data, e_word[23:0]);
                    chk("pix_idx", pix_idx, e_word[29:24]);
                    chk("overflow_err", err, e_word[30]);
                    chk("word_latency", cyc - word_fall_cyc, 3);
                    chk("valid_done_excl", frame_done, 0);
                end
                last_rgb = rgb_data;
            end
            if (frame_done) begin
                if (exp_frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got pix_count %0d, expected no frame", pix_count);
                end else begin
                    e_frame = exp_frame_q.pop_front();
                    chk("pix_count", pix_count, e_frame[6:0]);
                    chk("partial_err", err, e_frame[7]);
                end
                last_pc = pix_count;
            end
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk_outputs_zero("reset");
        sys_rst_n = 1'b1;

        // single spec-timed word
        frame_end(3000);
        send_word(24'hA5C3F0, 1'b0);
        frame_end(3000);
        checkpoint("single_word");
        chk("single_word_lit_data", last_rgb, 24'hA5C3F0);
        chk("single_word_lit_count", last_pc, 7'd1);

        // 64 words fill the frame; the 65th exercises pixel-index saturation
        for (int i = 0; i <= 64; i++) send_word(24'(i * 24'h030201), 1'b1);
        frame_end(2600);
        checkpoint("full_frame");
        chk("full_frame_lit_data", last_rgb, 24'hC08040);
        chk("full_frame_lit_count", last_pc, 7'd64);

        // threshold edges, minimum legal width and a glitch between bits
        for (int i = 0; i < 22; i++) pulse((i == 3) ? 5 : 15, 47);
        pulse(30, 32);
        pulse(4, 20);
        pulse(31, 31);
        frame_end(2600);
        checkpoint("threshold");
        chk("threshold_lit_data", last_rgb, 24'h000001);

        // partial word at reset, then a word containing a long legal gap
        for (int i = 0; i < 10; i++) pulse(47, 15);
        frame_end(2500);
        checkpoint("partial");
        chk("partial_lit_count", last_pc, 7'd0);
        for (int i = 23; i >= 0; i--) begin
            logic [23:0] w;
            w = 24'h123456;
            pulse(w[i] ? 47 : 15, (i == 17) ? 2000 : (w[i] ? 15 : 47));
        end
        frame_end(2600);
        checkpoint("after_partial");
        chk("after_partial_lit_data", last_rgb, 24'h123456);

        // over-long pulse: ignored line until a full reset low
        pulse(150, 100);
        pulse(47, 15);
        frame_end(3000);
        send_word(24'h00FF00, 1'b0);
        frame_end(2600);
        checkpoint("long_pulse");
        chk("long_pulse_lit_data", last_rgb, 24'h00FF00);

        // asynchronous reset in the middle of bit 12
        for (int i = 0; i < 12; i++) pulse(47, 15);
        din = 1'b1;
        repeat (5) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_word_reset");
        m_idle = 1'b1;
        m_bits = 0;
        m_pix  = 0;
        din    = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        frame_end(3000);
        send_word(24'hABCDEF, 1'b0);
        frame_end(2600);
        checkpoint("after_reset");
        chk("after_reset_lit_data", last_rgb, 24'hABCDEF);
        chk("after_reset_lit_count", last_pc, 7'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
